// File: rtl/ofifo_if.sv
// Row-release output FIFO bus: per-lane psum writes in, full-row FWFT readout out.
interface ofifo_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [col*psum_bw-1:0] in;
  logic [col-1:0]         wr;
  logic                   rd;
  logic [col*psum_bw-1:0] out;
  logic                   o_valid;
  logic                   o_full;
  logic                   o_ready;
  logic                   o_overflow;

  modport master (
    output in, wr, rd,
    input  out, o_valid, o_full, o_ready, o_overflow
  );

  modport slave (
    input  in, wr, rd,
    output out, o_valid, o_full, o_ready, o_overflow
  );
endinterface

// File: rtl/ofifo.sv
// Per-column output FIFO behind the MAC array; lanes fill independently and a
// row is released (first-word-fall-through) only once every lane holds data.
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 16
) (
  input  logic   clk,
  input  logic   reset,
  ofifo_if.slave bus
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic signed [psum_bw-1:0] mem [col][depth];
  logic [AW:0]               wptr [col];
  logic [AW:0]               rptr [col];
  logic [col-1:0]            empty;
  logic [col-1:0]            full;
  logic                      valid;
  logic                      pop;
  logic                      overflow;

  // Full/empty use the extra wrap bit so pointers can run modulo 2*depth freely.
  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < col; i++) begin
      empty[i] = (wptr[i] == rptr[i]);
      full[i]  = (wptr[i][AW] != rptr[i][AW]) &&
                 (wptr[i][AW-1:0] == rptr[i][AW-1:0]);
    end
  end

  assign valid = ~|empty;
  assign pop   = bus.rd && valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        if (bus.wr[i] && !full[i])
          wptr[i] <= wptr[i] + PTR_ONE;
        if (pop)
          rptr[i] <= rptr[i] + PTR_ONE;
      end
      if (|(bus.wr & full))
        overflow <= 1'b1;
    end
  end

  // Storage carries data only; contents are never cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (!reset && bus.wr[i] && !full[i])
        mem[i][wptr[i][AW-1:0]] <= bus.in[i*psum_bw +: psum_bw];
    end
  end

  always_comb begin
    bus.out = '0;
    if (valid) begin
      for (int i = 0; i < col; i++)
        bus.out[i*psum_bw +: psum_bw] = mem[i][rptr[i][AW-1:0]];
    end
  end

  assign bus.o_valid    = valid;
  assign bus.o_full     = |full;
  assign bus.o_ready    = ~|full;
  assign bus.o_overflow = overflow;

endmodule
